// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared constants and helpers for the arbitrated N:1 mux.
// Arbitration mode codes, a clog2 (min 1) and a channel-slice offset helper.
package arb_mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int chan_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/arb_mux_nto1_rr_pick.sv
// rr_pick: rotated priority encoder; first req at or above ptr, wrapping.
// Ports: req (per channel), ptr -> gnt (one-hot), idx (grant index), any.
module rr_pick #(
  parameter int N      = 4,
  parameter int CHAN_W = 2
) (
  input  logic [0:N-1]      req,
  input  logic [0:CHAN_W-1] ptr,
  output logic [0:N-1]      gnt,
  output logic [0:CHAN_W-1] idx,
  output logic              any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = CHAN_W'(c);
      end
    end
  end

endmodule

// File: rtl/arb_mux_nto1.sv
// arb_mux_nto1: N-input valid/ready mux with internal arbiter and one
// registered output stage. Ports: clk, reset, in_valid/in_data/in_ready,
// out_valid/out_data/out_chan/out_ready; in_last with ARB_MUX_LOCK_EN.
module arb_mux_nto1
  import arb_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int N      = 4,
  parameter int MODE   = 0,
  parameter int CHAN_W = clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:N-1]         in_valid,
  input  logic [0:N*WIDTH-1]   in_data,
  output logic [0:N-1]         in_ready,
  output logic                 out_valid,
  output logic [0:WIDTH-1]     out_data,
  output logic [0:CHAN_W-1]    out_chan,
`ifdef ARB_MUX_LOCK_EN
  input  logic [0:N-1]         in_last,
`endif
  input  logic                 out_ready
);

  logic              load_en;
  logic              any;
  logic              xfer;
  logic [0:N-1]      req;
  logic [0:N-1]      gnt;
  logic [0:CHAN_W-1] ptr;
  logic [0:CHAN_W-1] ptr_use;
  logic [0:CHAN_W-1] ptr_nxt;
  logic [0:CHAN_W-1] idx;
  logic [0:WIDTH-1]  sel_data;

  assign load_en = (!out_valid || out_ready) && !reset;

`ifdef ARB_MUX_LOCK_EN
  logic              locked;
  logic [0:CHAN_W-1] lock_chan;

  // A locked burst masks every other channel, even if its owner idles.
  always_comb begin
    req = '0;
    if (locked) req[lock_chan] = in_valid[lock_chan];
    else        req = in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked    <= 1'b0;
      lock_chan <= '0;
    end else if (xfer) begin
      locked    <= !in_last[idx];
      lock_chan <= idx;
    end
  end
`else
  assign req = in_valid;
`endif

  assign ptr_use = (MODE == ARB_FIXED) ? '0 : ptr;

  rr_pick #(
    .N      (N),
    .CHAN_W (CHAN_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_use),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign in_ready = gnt & {N{load_en}};
  assign xfer     = any && load_en;
  assign sel_data = in_data[chan_lo(int'(idx), WIDTH) +: WIDTH];

  always_comb begin
    if (int'(idx) == N - 1) ptr_nxt = '0;
    else                    ptr_nxt = idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= idx;
        if (MODE == ARB_RR) ptr <= ptr_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
